otter_csr_intr: RTL and testbench

- Machine-mode CSR file and interrupt front end for the OTTER MCU.
- Sits directly downstream of the control-unit FSM and consumes its csr_WE and int_taken strobes.
- Synchronises the raw external interrupt, latches it as pending, and gates it with the enable bits to produce the intr request back to the FSM.
- Supplies mtvec and mepc to the PC mux and returns CSR read data to the register-file write mux.

---
 rtl/otter_csr_intr.sv | 124 ++++++++++++
 tb/tb_otter_csr_intr.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/otter_csr_intr.sv
// Machine-mode CSR file and external-interrupt front end for the OTTER MCU.
// Holds mstatus (MIE/MPIE), mie (MEIE), mtvec, mepc and mcause, synchronises
// the raw interrupt line, latches a pending flag and raises intr to the FSM.
module otter_csr_intr #(
    parameter logic [31:0] MCAUSE_EXT = 32'h8000000B,
    parameter logic [31:0] MTVEC_RST  = 32'h00000000
) (
    input  logic        clk,
    input  logic        RST,
    input  logic        intr_in,
    input  logic        int_taken,
    input  logic        csr_WE,
    input  logic        mret,
    input  logic [11:0] addr,
    input  logic [31:0] wd,
    input  logic [31:0] pc,
    output logic [31:0] rd,
    output logic [31:0] mtvec,
    output logic [31:0] mepc,
    output logic        intr
);

    localparam logic [11:0] ADDR_MSTATUS = 12'h300;
    localparam logic [11:0] ADDR_MIE     = 12'h304;
    localparam logic [11:0] ADDR_MTVEC   = 12'h305;
    localparam logic [11:0] ADDR_MEPC    = 12'h341;
    localparam logic [11:0] ADDR_MCAUSE  = 12'h342;

    logic        mstatus_mie_q, mstatus_mie_d;
    logic        mstatus_mpie_q, mstatus_mpie_d;
    logic        mie_meie_q, mie_meie_d;
    logic [31:0] mtvec_q, mtvec_d;
    logic [31:0] mepc_q, mepc_d;
    logic [31:0] mcause_q, mcause_d;
    logic        sync_s1_q, sync_s2_q, sync_s3_q;
    logic        pending_q, pending_d;
    logic        intr_edge;
    logic        wr_mstatus, wr_mie, wr_mtvec, wr_mepc, wr_mcause;

    assign intr_edge  = sync_s2_q & ~sync_s3_q;
    assign wr_mstatus = csr_WE && (addr == ADDR_MSTATUS);
    assign wr_mie     = csr_WE && (addr == ADDR_MIE);
    assign wr_mtvec   = csr_WE && (addr == ADDR_MTVEC);
    assign wr_mepc    = csr_WE && (addr == ADDR_MEPC);
    assign wr_mcause  = csr_WE && (addr == ADDR_MCAUSE);

    // Next-state: trap entry beats mret, which beats a CSR write to mstatus.
    always_comb begin
        mstatus_mie_d  = mstatus_mie_q;
        mstatus_mpie_d = mstatus_mpie_q;
        mie_meie_d     = mie_meie_q;
        mtvec_d        = mtvec_q;
        mepc_d         = mepc_q;
        mcause_d       = mcause_q;

        // mie and mtvec are untouched by trap entry, so their writes always land.
        if (wr_mie) mie_meie_d = wd[11];
        if (wr_mtvec) mtvec_d = wd & ~32'd3;

        if (int_taken) begin
            mstatus_mpie_d = mstatus_mie_q;
            mstatus_mie_d  = 1'b0;
            mepc_d         = pc & ~32'd3;
            mcause_d       = MCAUSE_EXT;
        end else begin
            if (mret) begin
                mstatus_mie_d  = mstatus_mpie_q;
                mstatus_mpie_d = 1'b1;
            end else if (wr_mstatus) begin
                mstatus_mie_d  = wd[3];
                mstatus_mpie_d = wd[7];
            end
            if (wr_mepc) mepc_d = wd & ~32'd3;
            if (wr_mcause) mcause_d = wd;
        end

        // A fresh edge wins over a same-cycle acknowledge.
        pending_d = intr_edge | (pending_q & ~int_taken);
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!RST) begin
            mstatus_mie_q  <= 1'b0;
            mstatus_mpie_q <= 1'b0;
            mie_meie_q     <= 1'b0;
            mtvec_q        <= MTVEC_RST;
            mepc_q         <= 32'h0;
            mcause_q       <= 32'h0;
            sync_s1_q      <= 1'b0;
            sync_s2_q      <= 1'b0;
            sync_s3_q      <= 1'b0;
            pending_q      <= 1'b0;
        end else begin
            mstatus_mie_q  <= mstatus_mie_d;
            mstatus_mpie_q <= mstatus_mpie_d;
            mie_meie_q     <= mie_meie_d;
            mtvec_q        <= mtvec_d;
            mepc_q         <= mepc_d;
            mcause_q       <= mcause_d;
            sync_s1_q      <= intr_in;
            sync_s2_q      <= sync_s1_q;
            sync_s3_q      <= sync_s2_q;
            pending_q      <= pending_d;
        end
    end

    // CSR read mux shows the pre-write value (CSRRW old-value semantics).
    always_comb begin
        case (addr)
            ADDR_MSTATUS: rd = {24'h0, mstatus_mpie_q, 3'b000, mstatus_mie_q, 3'b000};
            ADDR_MIE:     rd = {20'h0, mie_meie_q, 11'h0};
            ADDR_MTVEC:   rd = mtvec_q;
            ADDR_MEPC:    rd = mepc_q;
            ADDR_MCAUSE:  rd = mcause_q;
            default:      rd = 32'h0;
        endcase
    end

    assign mtvec = mtvec_q;
    assign mepc  = mepc_q;
    assign intr  = pending_q & mstatus_mie_q & mie_meie_q;

endmodule

// File: tb/tb_otter_csr_intr.sv
// Scoreboard bench for otter_csr_intr: directed test-plan sequences followed by
// randomized traffic, checked against a word-level CSR model.
module tb_otter_csr_intr;

    localparam logic [31:0] MCAUSE_EXT = 32'h8000000B;
    localparam logic [31:0] MTVEC_RST  = 32'h00000000;

    logic        clk = 1'b0;
    logic        RST, intr_in, int_taken, csr_WE, mret;
    logic [11:0] addr;
    logic [31:0] wd, pc, rd, mtvec, mepc;
    logic        intr;

    otter_csr_intr #(
        .MCAUSE_EXT(MCAUSE_EXT),
        .MTVEC_RST (MTVEC_RST)
    ) dut (
        .clk      (clk),
        .RST      (RST),
        .intr_in  (intr_in),
        .int_taken(int_taken),
        .csr_WE   (csr_WE),
        .mret     (mret),
        .addr     (addr),
        .wd       (wd),
        .pc       (pc),
        .rd       (rd),
        .mtvec    (mtvec),
        .mepc     (mepc),
        .intr     (intr)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [11:0] a;
        logic [31:0] rd;
        logic [31:0] mtvec;
        logic [31:0] mepc;
        logic        intr;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    // Reference model: whole CSR words plus a history of sampled intr_in values.
    logic [31:0] m_mstatus, m_mie, m_mtvec, m_mepc, m_mcause;
    logic        m_pend;
    logic [2:0]  m_hist;   // [0] = most recent sample
    bit          m_valid = 0;

    function automatic logic [31:0] m_read(input logic [11:0] a);
        case (a)
            12'h300: return m_mstatus;
            12'h304: return m_mie;
            12'h305: return m_mtvec;
            12'h341: return m_mepc;
            12'h342: return m_mcause;
            default: return 32'h0;
        endcase
    endfunction

    task automatic m_step(input bit r, input bit ii, input bit it, input bit we, input bit mr,
                          input logic [11:0] a, input logic [31:0] w, input logic [31:0] p);
        logic [31:0] old_ms;
        bit          rise;
        if (!r) begin
            m_mstatus = 0; m_mie = 0; m_mtvec = MTVEC_RST; m_mepc = 0; m_mcause = 0;
            m_pend = 0; m_hist = 3'b000; m_valid = 1;
            return;
        end
        old_ms = m_mstatus;
        // Interrupt line rose two samples ago.
        rise   = m_hist[1] && !m_hist[2];
        m_hist = {m_hist[1:0], ii};
        m_pend = rise || (m_pend && !it);
        if (we && a == 12'h304) m_mie = w & 32'h800;
        if (we && a == 12'h305) m_mtvec = w & 32'hFFFFFFFC;
        if (it) begin
            m_mstatus = old_ms[3] ? 32'h80 : 32'h0;
            m_mepc    = p & 32'hFFFFFFFC;
            m_mcause  = MCAUSE_EXT;
        end else begin
            if (mr) m_mstatus = 32'h80 | (old_ms[7] ? 32'h8 : 32'h0);
            else if (we && a == 12'h300) m_mstatus = w & 32'h88;
            if (we && a == 12'h341) m_mepc = w & 32'hFFFFFFFC;
            if (we && a == 12'h342) m_mcause = w;
        end
    endtask

    // One clock of stimulus; expected outputs for this cycle go to the scoreboard.
    task automatic cyc(input bit r, input bit ii, input bit it, input bit we, input bit mr,
                       input logic [11:0] a, input logic [31:0] w, input logic [31:0] p);
        exp_t e;
        RST = r; intr_in = ii; int_taken = it; csr_WE = we; mret = mr;
        addr = a; wd = w; pc = p;
        if (m_valid) begin
            e.a     = a;
            e.rd    = m_read(a);
            e.mtvec = m_mtvec;
            e.mepc  = m_mepc;
            e.intr  = m_pend && m_mstatus[3] && m_mie[11];
            exp_q.push_back(e);
        end
        @(posedge clk);
        m_step(r, ii, it, we, mr, a, w, p);
        #1;
    endtask

    task automatic rdc(input logic [11:0] a, input bit ii);
        cyc(1, ii, 0, 0, 0, a, 32'h0, 32'h0);
    endtask

    task automatic wr(input logic [11:0] a, input logic [31:0] w);
        cyc(1, 0, 0, 1, 0, a, w, 32'h0);
    endtask

    // Monitor: compares DUT outputs mid-cycle against the queued expectation.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            n_cmp += 4;
            if (rd !== e.rd) begin
                n_err++;
                $display("FAIL rd@%h: got %h expected %h (t=%0t)", e.a, rd, e.rd, $time);
            end
            if (mtvec !== e.mtvec) begin
                n_err++;
                $display("FAIL mtvec: got %h expected %h (t=%0t)", mtvec, e.mtvec, $time);
            end
            if (mepc !== e.mepc) begin
                n_err++;
                $display("FAIL mepc: got %h expected %h (t=%0t)", mepc, e.mepc, $time);
            end
            if (intr !== e.intr) begin
                n_err++;
                $display("FAIL intr: got %b expected %b (t=%0t)", intr, e.intr, $time);
            end
        end
    end

    logic [11:0] addrs [7];
    bit          ii_lvl;

    initial begin
        addrs = '{12'h300, 12'h304, 12'h305, 12'h341, 12'h342, 12'h123, 12'h000};
        RST = 0; intr_in = 0; int_taken = 0; csr_WE = 0; mret = 0;
        addr = 0; wd = 0; pc = 0;
        @(posedge clk); #1;

        // Reset and post-reset state.
        cyc(0, 0, 0, 0, 0, 12'h305, 0, 0);
        cyc(0, 0, 0, 0, 0, 12'h305, 0, 0);
        rdc(12'h305, 0);
        rdc(12'h300, 0);

        // Enable, request, take.
        wr(12'h300, 32'h8);
        wr(12'h304, 32'h800);
        rdc(12'h300, 1);
        rdc(12'h300, 1);
        rdc(12'h300, 1);
        rdc(12'h304, 0);
        cyc(1, 0, 1, 0, 0, 12'h300, 0, 32'h1236);
        rdc(12'h300, 0);
        rdc(12'h341, 0);
        rdc(12'h342, 0);

        // Masked latch, then enable.
        rdc(12'h300, 1);
        rdc(12'h300, 1);
        for (int i = 0; i < 3; i++) rdc(12'h300, 0);
        wr(12'h300, 32'h8);
        rdc(12'h300, 0);

        // Trap then MRET with a colliding mstatus write.
        cyc(1, 0, 1, 0, 0, 12'h300, 0, 32'h200);
        rdc(12'h300, 0);
        cyc(1, 0, 0, 1, 1, 12'h300, 32'h0, 0);
        rdc(12'h300, 0);

        // int_taken collisions with mepc and mtvec writes.
        cyc(1, 0, 1, 1, 0, 12'h341, 32'hAAAA0000, 32'h40);
        rdc(12'h341, 0);
        cyc(1, 0, 1, 1, 0, 12'h305, 32'hAAAA0000, 32'h44);
        rdc(12'h305, 0);

        // Boundaries.
        wr(12'h305, 32'hFFFFFFFF);
        rdc(12'h305, 0);
        wr(12'h123, 32'hFFFFFFFF);
        rdc(12'h123, 0);

        // New edge landing on the same cycle as int_taken.
        wr(12'h300, 32'h8);
        rdc(12'h300, 1);
        rdc(12'h300, 1);
        rdc(12'h300, 0);
        rdc(12'h300, 0);
        rdc(12'h300, 1);
        rdc(12'h300, 1);
        cyc(1, 0, 1, 0, 0, 12'h300, 0, 32'h80);
        cyc(1, 0, 0, 0, 1, 12'h300, 0, 0);
        rdc(12'h300, 0);
        rdc(12'h300, 0);

        // Randomized traffic, including occasional mid-run reset.
        ii_lvl = 0;
        for (int i = 0; i < 1500; i++) begin
            logic [11:0] a;
            logic [31:0] w;
            if ($urandom_range(0, 5) == 0) ii_lvl = ~ii_lvl;
            a = addrs[$urandom_range(0, 6)];
            if (a == 12'h000) a = 12'($urandom);
            w = ($urandom_range(0, 2) == 0) ? 32'hFFFFFFFF : $urandom;
            cyc($urandom_range(0, 99) != 0, ii_lvl, $urandom_range(0, 9) == 0,
                $urandom_range(0, 2) == 0, $urandom_range(0, 9) == 0, a, w, $urandom);
        end

        RST = 1; csr_WE = 0; int_taken = 0; mret = 0;
        for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(posedge clk);
        if (exp_q.size() > 0) begin
            n_err++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
